// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_ctrl
//  Description : 4-bit LED sequencer with a built-in prescaler and four
//                selectable patterns: blink, rotate, ping-pong and binary
//                count. A synchronised push-button cycles through the modes.
//  Revision    : 1.0  initial release
// ============================================================================
module led_pattern_ctrl #(
  parameter int N = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode_btn,
  output logic [3:0] data,
  output logic [1:0] mode,
  output logic       tick
);

  typedef enum logic [1:0] {
    MODE_BLINK    = 2'd0,
    MODE_ROTATE   = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_COUNT    = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [N-1:0] CNT_LAST = '1;
  localparam logic [N-1:0] CNT_ONE  = N'(1);

  // Prescaler count; the step tick fires on its last value.
  logic [N-1:0] count;

  // Button synchroniser (btn_s1, btn_s2) and edge-history flop (btn_s3).
  logic btn_s1;
  logic btn_s2;
  logic btn_s3;
  logic press;

  // Pattern state.
  mode_t      state;
  dir_t       dir;
  logic [1:0] next_mode_raw;
  mode_t      next_mode;
  logic [3:0] seed_data;
  logic [3:0] step_data;
  dir_t       step_dir;

  // Tick is decoded from the registered count and gated by run, so a
  // frozen prescaler can never emit a strobe.
  assign tick  = run & (count == CNT_LAST);

  // Rising edge of the synchronised button; holding it gives one event.
  assign press = btn_s2 & ~btn_s3;

  assign next_mode_raw = state + 2'd1;
  assign next_mode     = mode_t'(next_mode_raw);
  assign mode          = state;

  // Seed pattern loaded when entering the next mode.
  always_comb begin
    seed_data = 4'b0000;
    case (next_mode)
      MODE_BLINK:    seed_data = 4'b0000;
      MODE_ROTATE:   seed_data = 4'b0001;
      MODE_PINGPONG: seed_data = 4'b0001;
      MODE_COUNT:    seed_data = 4'b0000;
      default:       seed_data = 4'b0000;
    endcase
  end

  // One pattern step for the current mode; the bouncing bit reverses
  // direction when it reaches either end of the register.
  always_comb begin
    step_data = data;
    step_dir  = dir;
    case (state)
      MODE_BLINK: begin
        step_data = ~data;
      end
      MODE_ROTATE: begin
        step_data = {data[2:0], data[3]};
      end
      MODE_PINGPONG: begin
        if (dir == DIR_LEFT) begin
          if (data[3]) begin
            step_data = {1'b0, data[3:1]};
            step_dir  = DIR_RIGHT;
          end else begin
            step_data = {data[2:0], 1'b0};
          end
        end else begin
          if (data[0]) begin
            step_data = {data[2:0], 1'b0};
            step_dir  = DIR_LEFT;
          end else begin
            step_data = {1'b0, data[3:1]};
          end
        end
      end
      MODE_COUNT: begin
        step_data = data + 4'd1;
      end
      default: begin
        step_data = data;
      end
    endcase
  end

  // Sequencer state: button sampling, mode change (priority over a step),
  // prescaler advance and pattern step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
      count  <= '0;
      state  <= MODE_BLINK;
      dir    <= DIR_LEFT;
      data   <= 4'b0000;
    end else begin
      btn_s1 <= mode_btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      if (press) begin
        // A mode change restarts the period, so a coincident tick is dropped.
        state <= next_mode;
        data  <= seed_data;
        dir   <= DIR_LEFT;
        count <= '0;
      end else if (run) begin
        count <= count + CNT_ONE;
        if (tick) begin
          data <= step_data;
          dir  <= step_dir;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_ctrl
//  Description : Self-checking bench for led_pattern_ctrl with N=2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       mode_btn;
  logic [3:0] data;
  logic [1:0] mode;
  logic       tick;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] d;
    logic [1:0] m;
    logic       t;
  } exp_t;

  typedef struct {
    logic run;
    logic btn;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[12];

  led_pattern_ctrl #(.N(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .mode_btn (mode_btn),
    .data     (data),
    .mode     (mode),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  // Compare DUT outputs against one expected record.
  task automatic check(input string name, input exp_t e);
    checks++;
    if (data !== e.d || mode !== e.m || tick !== e.t) begin
      failures++;
      $display("FAIL %s: got data=%b mode=%0d tick=%b, want data=%b mode=%0d tick=%b",
               name, data, mode, tick, e.d, e.m, e.t);
    end
  endtask

  // One clock: drive inputs (called at a falling edge), queue the expected
  // post-edge outputs, then pop and compare just after the rising edge.
  task automatic cyc(input string name, input logic r, input logic b,
                     input logic [3:0] d, input logic [1:0] m, input logic t);
    exp_t e;
    run      = r;
    mode_btn = b;
    sb.push_back(exp_t'({d, m, t}));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(name, e);
    @(negedge clk);
  endtask

  // One full prescaler period with run=1, ending in a step prev -> next.
  task automatic run_step(input string name, input logic [3:0] prev,
                          input logic [3:0] next, input logic [1:0] m);
    cyc(name, 1'b1, 1'b0, prev, m, 1'b0);
    cyc(name, 1'b1, 1'b0, prev, m, 1'b0);
    cyc(name, 1'b1, 1'b0, prev, m, 1'b1);
    cyc(name, 1'b1, 1'b0, next, m, 1'b0);
  endtask

  // Hold the button 10 cycles with run=0; the update lands on the 3rd edge.
  task automatic press(input string name, input logic [3:0] od, input logic [1:0] om,
                       input logic [3:0] nd, input logic [1:0] nm);
    for (int k = 0; k < 10; k++)
      cyc(name, 1'b0, 1'b1, (k < 2) ? od : nd, (k < 2) ? om : nm, 1'b0);
    for (int k = 0; k < 3; k++)
      cyc(name, 1'b0, 1'b0, nd, nm, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] pp_seq  [8];
    logic [3:0] cnt_seq [17];
    logic [3:0] rot_seq [4];
    logic [3:0] prev;

    pp_seq  = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4};
    for (int i = 0; i < 15; i++) cnt_seq[i] = 4'(i + 1);
    cnt_seq[15] = 4'h0;
    cnt_seq[16] = 4'h1;
    rot_seq = '{4'h2, 4'h4, 4'h8, 4'h1};

    // Blink after reset: tick on edges 3,7,11; data toggles on 4,8,12.
    tbl[0]  = '{1'b1, 1'b0, exp_t'({4'h0, 2'd0, 1'b0})};
    tbl[1]  = '{1'b1, 1'b0, exp_t'({4'h0, 2'd0, 1'b0})};
    tbl[2]  = '{1'b1, 1'b0, exp_t'({4'h0, 2'd0, 1'b1})};
    tbl[3]  = '{1'b1, 1'b0, exp_t'({4'hF, 2'd0, 1'b0})};
    tbl[4]  = '{1'b1, 1'b0, exp_t'({4'hF, 2'd0, 1'b0})};
    tbl[5]  = '{1'b1, 1'b0, exp_t'({4'hF, 2'd0, 1'b0})};
    tbl[6]  = '{1'b1, 1'b0, exp_t'({4'hF, 2'd0, 1'b1})};
    tbl[7]  = '{1'b1, 1'b0, exp_t'({4'h0, 2'd0, 1'b0})};
    tbl[8]  = '{1'b1, 1'b0, exp_t'({4'h0, 2'd0, 1'b0})};
    tbl[9]  = '{1'b1, 1'b0, exp_t'({4'h0, 2'd0, 1'b0})};
    tbl[10] = '{1'b1, 1'b0, exp_t'({4'h0, 2'd0, 1'b1})};
    tbl[11] = '{1'b1, 1'b0, exp_t'({4'hF, 2'd0, 1'b0})};

    rst      = 1'b1;
    run      = 1'b1;
    mode_btn = 1'b0;
    #12;
    check("reset", exp_t'({4'h0, 2'd0, 1'b0}));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      cyc("blink_tbl", tbl[i].run, tbl[i].btn, tbl[i].e.d, tbl[i].e.m, tbl[i].e.t);

    // Mode cycling with ticks frozen by run=0.
    press("mode_1", 4'hF, 2'd0, 4'h1, 2'd1);
    press("mode_2", 4'h1, 2'd1, 4'h1, 2'd2);
    press("mode_3", 4'h1, 2'd2, 4'h0, 2'd3);
    press("mode_0", 4'h0, 2'd3, 4'h0, 2'd0);
    press("to_rot", 4'h0, 2'd0, 4'h1, 2'd1);
    press("to_pp",  4'h1, 2'd1, 4'h1, 2'd2);

    prev = 4'h1;
    for (int i = 0; i < 8; i++) begin
      run_step("pingpong", prev, pp_seq[i], 2'd2);
      prev = pp_seq[i];
    end

    press("to_cnt", 4'h4, 2'd2, 4'h0, 2'd3);
    prev = 4'h0;
    for (int i = 0; i < 17; i++) begin
      run_step("count", prev, cnt_seq[i], 2'd3);
      prev = cnt_seq[i];
    end

    press("to_blk", 4'h1, 2'd3, 4'h0, 2'd0);
    press("to_rot2", 4'h0, 2'd0, 4'h1, 2'd1);
    prev = 4'h1;
    for (int i = 0; i < 4; i++) begin
      run_step("rotate", prev, rot_seq[i], 2'd1);
      prev = rot_seq[i];
    end

    // Run gating: freeze at count 2 for 7 cycles, then finish the period.
    cyc("gate_pre", 1'b1, 1'b0, 4'h1, 2'd1, 1'b0);
    cyc("gate_pre", 1'b1, 1'b0, 4'h1, 2'd1, 1'b0);
    for (int k = 0; k < 7; k++)
      cyc("gate_hold", 1'b0, 1'b0, 4'h1, 2'd1, 1'b0);
    cyc("gate_resume", 1'b1, 1'b0, 4'h1, 2'd1, 1'b1);
    cyc("gate_step", 1'b1, 1'b0, 4'h2, 2'd1, 1'b0);

    // Press lands on the same edge as a tick: mode wins, no step.
    cyc("coll", 1'b1, 1'b0, 4'h2, 2'd1, 1'b0);
    cyc("coll", 1'b1, 1'b1, 4'h2, 2'd1, 1'b0);
    cyc("coll", 1'b1, 1'b1, 4'h2, 2'd1, 1'b1);
    cyc("coll_press", 1'b1, 1'b1, 4'h1, 2'd2, 1'b0);
    cyc("coll_after", 1'b1, 1'b1, 4'h1, 2'd2, 1'b0);
    cyc("coll_after", 1'b1, 1'b0, 4'h1, 2'd2, 1'b0);
    cyc("coll_after", 1'b1, 1'b0, 4'h1, 2'd2, 1'b1);
    cyc("coll_step", 1'b1, 1'b0, 4'h2, 2'd2, 1'b0);
    run_step("coll_pp", 4'h2, 4'h4, 2'd2);

    // Asynchronous reset between edges.
    #1;
    rst = 1'b1;
    #1;
    check("async_rst", exp_t'({4'h0, 2'd0, 1'b0}));
    @(posedge clk);
    #1;
    check("rst_held", exp_t'({4'h0, 2'd0, 1'b0}));
    @(negedge clk);
    rst = 1'b0;
    run_step("post_rst", 4'h0, 4'hF, 2'd0);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got %0d left, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Controller that sequences the 4-bit LED register.
- Contains its own prescaler that generates a step tick, plus a 4-mode pattern state machine: blink, rotate, ping-pong and binary count.
- A push-button input cycles through the modes.
- Sits between the board clock and the LED pins; it replaces the free-running invert-register blinker with a selectable, resettable sequencer.

Parameters:
- N, 22, prescaler width in bits; step tick period = 2^N clk cycles; legal range N >= 1 (benches use N=2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  synchronous enable; 0 freezes prescaler and pattern.
- mode_btn  input  1  raw push-button, asynchronous to clk, active-high.
- data  output  4  LED register contents; registered.
- mode  output  2  current mode; registered.
- tick  output  1  step strobe; high exactly one cycle per prescaler wrap.

Behaviour:
- Reset (async, active-high) forces:
  - data=0000, mode=0, dir=LEFT, prescaler count=0.
  - Both button sync flops and the edge-history flop = 0.
  - tick therefore reads 0.
- Prescaler:
  - N-bit count increments by 1 on each edge while run=1; wraps from 2^N-1 to 0.
  - tick = run AND (count == 2^N-1), decoded combinationally from registered count.
- Step rule: on an edge with tick=1 and no mode change, data advances one step per the current mode.
- Modes and steps:
  - 0 BLINK: data <= ~data. Seed 0000.
  - 1 ROTATE: data <= {data[2:0],data[3]}. Seed 0001. Any nonzero value rotates; 0000 stays 0000.
  - 2 PINGPONG: seed 0001, dir=LEFT.
    - dir LEFT: if data[3]=1 then data<=data>>1 and dir<=RIGHT; else data<=data<<1.
    - dir RIGHT: if data[0]=1 then data<=data<<1 and dir<=LEFT; else data<=data>>1.
    - Sequence: 0001,0010,0100,1000,0100,0010,0001,0010,...
  - 3 COUNT: data <= data+1 mod 16; 1111 wraps to 0000. Seed 0000.
- Button path:
  - mode_btn passes through a 2-flop synchronizer (s1, s2), then a history flop s3.
  - press = s2 AND NOT s3.
  - The mode update lands on the 3rd rising edge at which mode_btn is sampled high, starting from the first.
  - Holding the button yields exactly one press; release produces no event.
  - Pulses shorter than one clk period may be missed; this is accepted.
- Mode change, on an edge with press=1:
  - mode <= mode+1 mod 4 (3 wraps to 0).
  - data <= seed of the new mode; dir <= LEFT; count <= 0.
  - Accepted regardless of run.
- Simultaneous press and tick: mode change wins; the step is discarded; the next step comes a full 2^N running cycles later.
- run=0:
  - count, data and dir hold; tick=0.
  - Re-asserting run resumes from the held count, with no extra or lost step.
- Reset mid-operation: all state returns to reset values immediately, independent of clk. After release, the first tick occurs at the 2^N-th edge with run=1.
- Latency:
  - data changes at the same edge where tick=1.
  - tick occurs every 2^N edges while run=1.

Test Plan:
- Reset/blink, N=2, run=1, btn=0, rst pulsed: data=0000, mode=0 during reset. tick high during cycles 4,8,12 after release. data = 1111,0000,1111 after those edges.
- Mode cycling: press btn (held 10 cycles) four times, ticks suppressed by run=0. mode goes 1,2,3,0; data = 0001,0001,0000,0000. Each update lands 3 edges after the btn rise. Holding the button produces a single increment.
- PINGPONG, N=2: 8 ticks after entering mode 2 → data = 0010,0100,1000,0100,0010,0001,0010,0100.
- COUNT wrap: in mode 3, 17 ticks → data = 0001..1111,0000,0001. ROTATE over 4 ticks from 0001 → 0010,0100,1000,0001.
- Run gating and collision:
  - Drop run for 7 cycles mid-period: count, data, tick frozen; resume keeps the period exact.
  - Align a press with tick: mode increments, data = new seed, no step, count = 0.
- Async reset: assert rst between clk edges while in mode 2 with data=0100. data=0000, mode=0 immediately, before the next edge. Normal blink resumes after release.
